// File: rtl/m72_pkg.sv
// Shared M72 constants: sound-CPU I/O port map and the Z80 RST vector masks
// used when the sound latch and the YM2151 request an interrupt.
package m72_pkg;

   localparam logic [7:0] SND_DATA_PORT   = 8'h02;
   localparam logic [7:0] SND_ACK_PORT    = 8'h06;
   localparam logic [7:0] SND_STATUS_PORT = 8'h04;

   localparam logic [7:0] RST_IDLE        = 8'hff;
   localparam logic [7:0] RST_YM_MASK     = 8'hef;
   localparam logic [7:0] RST_LATCH_MASK  = 8'hdf;

   // The vector is an RST opcode: each source clears its own bit of 8'hff.
   function automatic logic [7:0] rst_vector(input logic ym_req, input logic latch_req);
      logic [7:0] v;
      v = RST_IDLE;
      if (ym_req)
         v = v & RST_YM_MASK;
      if (latch_req)
         v = v & RST_LATCH_MASK;
      return v;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-clock rising-edge detector. During reset the history register tracks
// the input, so a level already high when reset releases is not an edge.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (reset)
         prev <= sig;
      else
         prev <= sig;
   end

   assign rise = sig & ~prev & ~reset;

endmodule

// File: rtl/m72_sound_latch.sv
// Main-CPU to sound-CPU command latch: holds the command byte and a pending
// flag, drives the Z80 INT line and answers the interrupt-acknowledge cycle.
module m72_sound_latch
   import m72_pkg::*;
#(
   parameter logic [7:0] DATA_PORT   = SND_DATA_PORT,
   parameter logic [7:0] ACK_PORT    = SND_ACK_PORT,
   parameter logic [7:0] STATUS_PORT = SND_STATUS_PORT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       latch_wr,
   input  logic [7:0] latch_data,
   input  logic [7:0] z80_addr,
   input  logic       z80_iorq,
   input  logic       z80_rd,
   input  logic       z80_wr,
   input  logic       z80_m1,
   input  logic       ym_irq,
   output logic [7:0] z80_dout,
   output logic       z80_dout_valid,
   output logic       z80_int,
   output logic       pending
);

   logic [7:0] latch;
   logic       overrun;

   logic io_cycle;
   logic int_ack;
   logic data_rd;
   logic status_rd;
   logic ack_wr;

   logic wr_rise;
   logic ack_rise;
   logic status_end;

   assign io_cycle  = z80_iorq & ~z80_m1;
   assign int_ack   = z80_iorq & z80_m1;
   assign data_rd   = io_cycle & z80_rd & (z80_addr == DATA_PORT);
   assign status_rd = io_cycle & z80_rd & (z80_addr == STATUS_PORT);
   assign ack_wr    = io_cycle & z80_wr & (z80_addr == ACK_PORT);

   rise_detect u_wr_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (latch_wr),
      .rise  (wr_rise)
   );

   rise_detect u_ack_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (ack_wr),
      .rise  (ack_rise)
   );

   // Rising edge of "not reading status" marks the end of a status read.
   rise_detect u_status_end (
      .clk   (clk),
      .reset (reset),
      .sig   (~status_rd),
      .rise  (status_end)
   );

   // The overrun clear comes first so a coincident overwrite still sets it;
   // a main-CPU write beats a simultaneous Z80 ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         latch   <= 8'h00;
         pending <= 1'b0;
         overrun <= 1'b0;
         z80_int <= 1'b0;
      end else begin
         if (status_end)
            overrun <= 1'b0;
         if (wr_rise) begin
            latch   <= latch_data;
            pending <= 1'b1;
            if (pending)
               overrun <= 1'b1;
         end else if (ack_rise) begin
            pending <= 1'b0;
         end
         z80_int <= pending | ym_irq;
      end
   end

   always_comb begin
      z80_dout       = RST_IDLE;
      z80_dout_valid = 1'b0;
      if (int_ack) begin
         z80_dout       = rst_vector(ym_irq, pending);
         z80_dout_valid = 1'b1;
      end else if (data_rd) begin
         z80_dout       = latch;
         z80_dout_valid = 1'b1;
      end else if (status_rd) begin
         z80_dout       = {6'b000000, overrun, pending};
         z80_dout_valid = 1'b1;
      end
   end

endmodule

// File: tb/tb_m72_sound_latch.sv
// Scoreboard bench for m72_sound_latch: Z80 accesses queue their expected byte,
// a negedge monitor pops and compares whenever the DUT drives z80_dout.
module tb_m72_sound_latch;

   typedef struct {
      string      name;
      logic [7:0] value;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       latch_wr;
   logic [7:0] latch_data;
   logic [7:0] z80_addr;
   logic       z80_iorq;
   logic       z80_rd;
   logic       z80_wr;
   logic       z80_m1;
   logic       ym_irq;
   logic [7:0] z80_dout;
   logic       z80_dout_valid;
   logic       z80_int;
   logic       pending;

   exp_t sbQ[$];
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   m72_sound_latch dut (
      .clk            (clk),
      .reset          (reset),
      .latch_wr       (latch_wr),
      .latch_data     (latch_data),
      .z80_addr       (z80_addr),
      .z80_iorq       (z80_iorq),
      .z80_rd         (z80_rd),
      .z80_wr         (z80_wr),
      .z80_m1         (z80_m1),
      .ym_irq         (ym_irq),
      .z80_dout       (z80_dout),
      .z80_dout_valid (z80_dout_valid),
      .z80_int        (z80_int),
      .pending        (pending)
   );

   // Every cycle the DUT drives the bus must match the oldest queued expectation.
   always @(negedge clk) begin
      if (z80_dout_valid === 1'b1) begin
         exp_t e;
         checks++;
         if (sbQ.size() == 0) begin
            $display("[TB] FAIL unexpected_valid: dout=%02h with nothing expected", z80_dout);
         end else begin
            e = sbQ.pop_front();
            if (z80_dout === e.value)
               passes++;
            else
               $display("[TB] FAIL %s: got %02h expected %02h", e.name, z80_dout, e.value);
         end
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual === expected)
         passes++;
      else
         $display("[TB] FAIL %s: got %02h expected %02h", name, actual, expected);
   endtask

   task automatic busIdle();
      z80_iorq = 1'b0;
      z80_rd   = 1'b0;
      z80_wr   = 1'b0;
      z80_m1   = 1'b0;
      z80_addr = 8'h00;
   endtask

   task automatic z80Read(input logic [7:0] addr, input logic [7:0] expected, input string name);
      sbQ.push_back('{name, expected});
      z80_addr = addr;
      z80_iorq = 1'b1;
      z80_rd   = 1'b1;
      tick();
      busIdle();
      tick();
   endtask

   task automatic intAck(input logic [7:0] expected, input string name);
      sbQ.push_back('{name, expected});
      z80_iorq = 1'b1;
      z80_m1   = 1'b1;
      tick();
      busIdle();
   endtask

   task automatic ackWrite();
      z80_addr = 8'h06;
      z80_iorq = 1'b1;
      z80_wr   = 1'b1;
      tick();
      busIdle();
   endtask

   task automatic mainWrite(input logic [7:0] data);
      latch_wr   = 1'b1;
      latch_data = data;
      tick();
      latch_wr   = 1'b0;
      tick();
   endtask

   task automatic applyStimulus();
      // Reset and idle state
      busIdle();
      reset = 1'b1; latch_wr = 1'b0; latch_data = 8'h00; ym_irq = 1'b0;
      tick(3);
      reset = 1'b0;
      tick();
      checkOutput("reset_pending", {7'b0, pending}, 8'h00);
      checkOutput("reset_int", {7'b0, z80_int}, 8'h00);
      checkOutput("reset_dout", z80_dout, 8'hff);
      checkOutput("reset_valid", {7'b0, z80_dout_valid}, 8'h00);

      // Held strobe captures once; INT follows pending by one clk
      latch_wr = 1'b1; latch_data = 8'h3a;
      tick();
      checkOutput("cap_pending", {7'b0, pending}, 8'h01);
      checkOutput("cap_int_lag", {7'b0, z80_int}, 8'h00);
      tick();
      checkOutput("cap_int", {7'b0, z80_int}, 8'h01);
      tick(3);
      latch_wr = 1'b0;
      z80Read(8'h02, 8'h3a, "data_read");
      checkOutput("read_keeps_pending", {7'b0, pending}, 8'h01);
      z80Read(8'h04, 8'h01, "status_single_capture");

      // Unmatched port and non-IORQ read leave the bus undriven
      z80_addr = 8'h03; z80_iorq = 1'b1; z80_rd = 1'b1;
      #1 checkOutput("unmatched_port_valid", {7'b0, z80_dout_valid}, 8'h00);
      checkOutput("unmatched_port_dout", z80_dout, 8'hff);
      z80_addr = 8'h02; z80_iorq = 1'b0;
      #1 checkOutput("no_iorq_valid", {7'b0, z80_dout_valid}, 8'h00);
      busIdle();
      tick();

      // Latch-only vector, then ack clears pending and INT a clk later
      intAck(8'hdf, "vector_latch");
      ackWrite();
      checkOutput("ack_pending", {7'b0, pending}, 8'h00);
      checkOutput("ack_int_lag", {7'b0, z80_int}, 8'h01);
      tick();
      checkOutput("ack_int", {7'b0, z80_int}, 8'h00);

      // YM only, both sources, then back to YM only
      ym_irq = 1'b1;
      tick();
      checkOutput("ym_int", {7'b0, z80_int}, 8'h01);
      intAck(8'hef, "vector_ym");
      mainWrite(8'h77);
      intAck(8'hcf, "vector_both");
      ackWrite();
      tick();
      intAck(8'hef, "vector_ym_after_ack");
      checkOutput("ym_int_held", {7'b0, z80_int}, 8'h01);
      ym_irq = 1'b0;
      tick(2);
      checkOutput("int_released", {7'b0, z80_int}, 8'h00);
      intAck(8'hff, "vector_spurious");

      // Overwrite without ack sets sticky overrun; status read clears it
      mainWrite(8'h11);
      mainWrite(8'h22);
      z80Read(8'h02, 8'h22, "overwrite_data");
      z80Read(8'h04, 8'h03, "status_overrun");
      z80Read(8'h04, 8'h01, "status_overrun_cleared");

      // Write edge and ack edge in the same clk: write wins
      latch_wr = 1'b1; latch_data = 8'h55;
      z80_addr = 8'h06; z80_iorq = 1'b1; z80_wr = 1'b1;
      tick();
      latch_wr = 1'b0;
      busIdle();
      tick();
      checkOutput("race_pending", {7'b0, pending}, 8'h01);
      checkOutput("race_int", {7'b0, z80_int}, 8'h01);
      z80Read(8'h02, 8'h55, "race_data");

      // Reset with pending set and the strobe held high
      latch_wr = 1'b1; latch_data = 8'h99;
      tick();
      reset = 1'b1;
      tick();
      checkOutput("rst_mid_pending", {7'b0, pending}, 8'h00);
      checkOutput("rst_mid_int", {7'b0, z80_int}, 8'h00);
      checkOutput("rst_mid_dout", z80_dout, 8'hff);
      reset = 1'b0;
      tick(3);
      checkOutput("held_strobe_no_capture", {7'b0, pending}, 8'h00);
      z80Read(8'h02, 8'h00, "latch_after_reset");
      latch_wr = 1'b0;
      tick();
      mainWrite(8'ha5);
      checkOutput("recapture_pending", {7'b0, pending}, 8'h01);
      z80Read(8'h02, 8'ha5, "recapture_data");
      tick(2);
   endtask

   initial begin
      applyStimulus();
      checkOutput("scoreboard_drained", 8'(sbQ.size()), 8'h00);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
